// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 16x2 character-LCD controller.
// Holds a 32-byte character buffer written by the system. After reset it waits for panel
// power-up, sends the initialisation commands and redraws the panel once. A refresh request
// redraws the panel from the buffer; requests arriving while busy collapse into one more redraw.
// Ports:
//   SYS_clk, SYS_rst        clock (rising edge), asynchronous active-high reset
//   wr_en/wr_addr/wr_data   buffer write port (addr 0-15 line 1, 16-31 line 2)
//   refresh                 redraw request, level sampled every cycle
//   ready                   1 when idle with nothing pending
//   LCD_DATA/EN/RS/RW/ON    panel parallel bus, strobe, register select, write-only, power
module lcd_refresh_ctrl #(
  parameter int unsigned EN_PULSE_CYC   = 16,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLR_WAIT_CYC   = 100000,
  parameter int unsigned PWRUP_WAIT_CYC = 1000000
) (
  input  logic       SYS_clk,
  input  logic       SYS_rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       ready,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON
);

  localparam int unsigned MaxA   = (CMD_WAIT_CYC > EN_PULSE_CYC) ? CMD_WAIT_CYC : EN_PULSE_CYC;
  localparam int unsigned MaxB   = (CLR_WAIT_CYC > MaxA) ? CLR_WAIT_CYC : MaxA;
  localparam int unsigned MaxCyc = (PWRUP_WAIT_CYC > MaxB) ? PWRUP_WAIT_CYC : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] PwrTgt = CntW'(PWRUP_WAIT_CYC);
  localparam logic [CntW-1:0] EnTgt  = CntW'(EN_PULSE_CYC);
  localparam logic [CntW-1:0] CmdTgt = CntW'(CMD_WAIT_CYC);
  localparam logic [CntW-1:0] ClrTgt = CntW'(CLR_WAIT_CYC);

  localparam logic [2:0] StPwrup = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StEnHi  = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StIdle  = 3'd5;

  // Transfer index: 0-3 init commands, 4-37 the 34 refresh transfers.
  localparam logic [5:0] FirstRefIdx = 6'd4;
  localparam logic [5:0] LastIdx     = 6'd37;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc, wait_tgt;
  logic [5:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [31:0][7:0] chr_q, chr_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             on_q;
  logic             start_xfer;

  // {RS, byte} for a given transfer index, reading the live buffer.
  function automatic logic [8:0] seq_byte(input logic [5:0] idx, input logic [31:0][7:0] chr);
    logic [5:0] r;
    logic [4:0] a;
    r = idx - FirstRefIdx;
    a = (r <= 6'd16) ? 5'(r - 6'd1) : 5'(r - 6'd2);
    if (idx == 6'd0)      seq_byte = {1'b0, 8'h38};
    else if (idx == 6'd1) seq_byte = {1'b0, 8'h0C};
    else if (idx == 6'd2) seq_byte = {1'b0, 8'h06};
    else if (idx == 6'd3) seq_byte = {1'b0, 8'h01};
    else if (r == 6'd0)   seq_byte = {1'b0, 8'h80};
    else if (r == 6'd17)  seq_byte = {1'b0, 8'hC0};
    else                  seq_byte = {1'b1, chr[a]};
  endfunction

  assign cnt_inc  = cnt_q + 1'b1;
  assign wait_tgt = (!rs_q && data_q == 8'h01) ? ClrTgt : CmdTgt;

  always_comb begin
    chr_d = chr_q;
    if (wr_en) chr_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    data_d     = data_q;
    rs_d       = rs_q;
    start_xfer = 1'b0;
    if (refresh && state_q != StIdle) pend_d = 1'b1;

    case (state_q)
      StPwrup: begin
        if (cnt_inc == PwrTgt) begin
          idx_d      = 6'd0;
          start_xfer = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSetup: begin
        state_d = StEnHi;
        cnt_d   = '0;
      end
      StEnHi: begin
        if (cnt_inc == EnTgt) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (cnt_inc == wait_tgt) begin
          if (idx_q != LastIdx) begin
            idx_d      = idx_q + 6'd1;
            start_xfer = 1'b1;
          end else if (pend_q || refresh) begin
            // Chain straight into another redraw; ready never rises in between.
            idx_d      = FirstRefIdx;
            pend_d     = 1'b0;
            start_xfer = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StIdle: begin
        if (refresh) begin
          idx_d      = FirstRefIdx;
          start_xfer = 1'b1;
        end
      end
      default: state_d = StPwrup;
    endcase

    if (start_xfer) begin
      state_d        = StSetup;
      cnt_d          = '0;
      {rs_d, data_d} = seq_byte(idx_d, chr_q);
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign en_d    = (state_d == StEnHi);
  assign ready_d = (state_d == StIdle);

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      chr_q   <= {32{8'h20}};
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      chr_q   <= chr_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      on_q    <= 1'b1;
    end
  end

  assign ready    = ready_q;
  assign LCD_DATA = data_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = on_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl with small timing parameters. A monitor records every EN pulse
// (byte, rise cycle, width, bus stability); the initial block compares the record against the
// transfer list a buffer model says the panel should receive.
module tb_lcd_refresh_ctrl;
  localparam int unsigned EnCyc = 2;
  localparam int unsigned CmdW  = 4;
  localparam int unsigned ClrW  = 8;
  localparam int unsigned PwrW  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh = 1'b0;
  logic       ready, en, rs, rw, on;
  logic [7:0] data;

  lcd_refresh_ctrl #(
    .EN_PULSE_CYC  (EnCyc),
    .CMD_WAIT_CYC  (CmdW),
    .CLR_WAIT_CYC  (ClrW),
    .PWRUP_WAIT_CYC(PwrW)
  ) dut (
    .SYS_clk (clk),
    .SYS_rst (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .refresh (refresh),
    .ready   (ready),
    .LCD_DATA(data),
    .LCD_EN  (en),
    .LCD_RS  (rs),
    .LCD_RW  (rw),
    .LCD_ON  (on)
  );

  always #5 clk = ~clk;

  // Edge count since reset release: edge k after release gives cyc == k.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [8:0] b;
    int         rise;
    int         len;
    bit         ok;
  } xfer_t;

  xfer_t      cap[$];
  xfer_t      cur;
  logic       en_prev = 1'b0;
  logic [8:0] prev_b = '0;
  int         rw_bad = 0;

  always @(negedge clk) begin
    if (rw !== 1'b0) rw_bad++;
    if (rst) begin
      en_prev = 1'b0;
    end else begin
      if (en && !en_prev) begin
        cur.b    = {rs, data};
        cur.rise = cyc;
        cur.len  = 1;
        cur.ok   = ({rs, data} === prev_b);
      end else if (en && en_prev) begin
        cur.len++;
        if ({rs, data} !== cur.b) cur.ok = 1'b0;
      end else if (!en && en_prev) begin
        if ({rs, data} !== cur.b) cur.ok = 1'b0;
        cap.push_back(cur);
      end
      en_prev = en;
    end
    prev_b = {rs, data};
  end

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] mdl[32];
  logic [8:0] expq[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic add_init();
    expq.push_back(9'h038);
    expq.push_back(9'h00C);
    expq.push_back(9'h006);
    expq.push_back(9'h001);
  endtask

  task automatic add_refresh();
    expq.push_back(9'h080);
    for (int i = 0; i < 16; i++) expq.push_back({1'b1, mdl[i]});
    expq.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) expq.push_back({1'b1, mdl[i]});
  endtask

  task automatic check_xfers(input int first_rise);
    int n;
    int gap;
    chk("xfer_count", cap.size(), expq.size());
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    if (first_rise >= 0 && n > 0) chk("first_en_rise", cap[0].rise, first_rise);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("xfer%0d_byte", i), cap[i].b, expq[i]);
      chk($sformatf("xfer%0d_en_len", i), cap[i].len, EnCyc);
      chk($sformatf("xfer%0d_bus_stable", i), cap[i].ok, 1);
      if (i > 0) begin
        gap = 2 + EnCyc + ((expq[i-1] == 9'h001) ? ClrW : CmdW);
        chk($sformatf("xfer%0d_spacing", i), cap[i].rise - cap[i-1].rise, gap);
      end
    end
    chk("rw_low", rw_bad, 0);
  endtask

  task automatic wait_ready(input int budget, output int at);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk("ready_wait", ready, 1);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("en_wait", en, 1);
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    mdl[a]  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_en", en, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_on", on, 0);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    cap.delete();
    expq.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    #1;
    chk("on_before_edge1", on, 0);
    @(negedge clk);
    chk("on_after_edge1", on, 1);
    chk("ready_low_pwrup", ready, 0);
  endtask

  initial begin
    int         at;
    int         t0;
    int         nw;
    logic [7:0] hello[5];
    hello[0] = 8'h48;
    hello[1] = 8'h45;
    hello[2] = 8'h4C;
    hello[3] = 8'h4C;
    hello[4] = 8'h4F;

    // Power-up: init commands then an automatic redraw of spaces.
    apply_reset();
    add_init();
    add_refresh();
    wait_ready(2000, at);
    chk("pwrup_ready_cycle", at, 318);
    check_xfers(11);

    // Buffer content written in IDLE.
    cap.delete();
    expq.delete();
    for (int i = 0; i < 5; i++) wr(5'(i), hello[i]);
    wr(5'd31, 8'h21);
    @(negedge clk);
    wr_en = 1'b0;
    pulse_refresh();
    chk("hello_ready_drop", ready, 0);
    t0 = cyc;
    add_refresh();
    wait_ready(1000, at);
    chk("hello_refresh_len", at - t0, 272);
    check_xfers(-1);

    // Random buffer contents.
    for (int r = 0; r < 2; r++) begin
      cap.delete();
      expq.delete();
      nw = $urandom_range(1, 12);
      for (int k = 0; k < nw; k++) wr(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
      @(negedge clk);
      wr_en = 1'b0;
      pulse_refresh();
      chk("rand_ready_drop", ready, 0);
      t0 = cyc;
      add_refresh();
      wait_ready(1000, at);
      chk("rand_refresh_len", at - t0, 272);
      check_xfers(-1);
    end

    // Late write to an unsent position plus three collapsing requests.
    cap.delete();
    expq.delete();
    pulse_refresh();
    t0 = cyc;
    begin
      int n = 0;
      while (!(cap.size() == 4 && en === 1'b1) && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("late_write_point", cap.size(), 4);
    end
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_data = 8'h5A;
    mdl[20] = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(10, 40)) @(negedge clk);
      pulse_refresh();
    end
    add_refresh();
    add_refresh();
    wait_ready(2000, at);
    chk("collapse_total_len", at - t0, 544);
    check_xfers(-1);

    // Asynchronous reset while EN is high.
    pulse_refresh();
    wait_en(100);
    #2 rst = 1'b1;
    #1 chk("en_async_drop", en, 0);
    apply_reset();
    add_init();
    add_refresh();
    wait_ready(2000, at);
    chk("rst_mid_ready_cycle", at, 318);
    check_xfers(11);

    // Request during power-up is serviced after the automatic redraw.
    apply_reset();
    pulse_refresh();
    add_init();
    add_refresh();
    add_refresh();
    wait_ready(3000, at);
    chk("pwrup_pending_ready_cycle", at, 590);
    check_xfers(11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
